// File: rtl/puf_response_builder_if.sv
// Connection bundle between the RO-PUF response builder, the post-mux counters
// and the response readout logic.
interface puf_response_builder_if #(
  parameter int N_BITS = 8,
  parameter int CW     = 8
);
  localparam int CHW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  logic              start;
  logic [CW-1:0]     count_a;
  logic              fin_a;
  logic [CW-1:0]     count_b;
  logic              fin_b;
  logic              cnt_reset;
  logic              cnt_enable;
  logic [CHW-1:0]    challenge;
  logic [N_BITS-1:0] response;
  logic              valid;
  logic              busy;
  logic              tie;
  logic              error;

  // The response builder itself
  modport slave (
    input  start, count_a, fin_a, count_b, fin_b,
    output cnt_reset, cnt_enable, challenge, response, valid, busy, tie, error
  );

  // Counters, readout logic or a testbench driving the builder
  modport master (
    output start, count_a, fin_a, count_b, fin_b,
    input  cnt_reset, cnt_enable, challenge, response, valid, busy, tie, error
  );
endinterface

// File: rtl/puf_response_builder.sv
// Sequences N_BITS ring-oscillator pair challenges through the two post-mux
// counters, compares each pair of counts and packs the bits into a response word.
module puf_response_builder #(
  parameter int N_BITS  = 8,
  parameter int CW      = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  puf_response_builder_if.slave bus
);
  localparam int CHW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CHW-1:0] LAST_CH  = CHW'(N_BITS - 1);
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [CHW-1:0]    r_challenge;
  logic [N_BITS-1:0] r_response;
  logic [CW-1:0]     r_lat_a;
  logic [CW-1:0]     r_lat_b;
  logic [WDW-1:0]    r_wd;
  logic              r_cnt_reset;
  logic              r_cnt_enable;
  logic              r_valid;
  logic              r_busy;
  logic              r_tie;
  logic              r_error;

  logic w_both_fin;
  logic w_timeout;
  logic w_last;
  logic w_accept;
  logic w_latch;
  logic w_compare;
  logic w_set_valid;
  logic w_set_error;

  assign w_both_fin = bus.fin_a && bus.fin_b;
  assign w_timeout  = (r_wd == WD_LIMIT);
  assign w_last     = (r_challenge == LAST_CH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: every sequential assignment uses <= so all registers update from
      // pre-edge values, independent of statement order.
      r_state <= w_next_state;
    end
  end

  always_comb begin
    // NOTE: defaults first, so every path assigns every signal and no latch
    // can be inferred.
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_latch      = 1'b0;
    w_compare    = 1'b0;
    w_set_valid  = 1'b0;
    w_set_error  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next_state = S_CLEAR;
          w_accept     = 1'b1;
        end
      end
      S_CLEAR: w_next_state = S_RUN;
      S_RUN: begin
        // Both flags win over a simultaneous watchdog expiry.
        if (w_both_fin) begin
          w_next_state = S_COMPARE;
          w_latch      = 1'b1;
        end else if (w_timeout) begin
          w_next_state = S_IDLE;
          w_set_error  = 1'b1;
        end
      end
      S_COMPARE: begin
        w_compare    = 1'b1;
        w_next_state = w_last ? S_DONE : S_CLEAR;
      end
      S_DONE: begin
        w_next_state = S_IDLE;
        w_set_valid  = 1'b1;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Counter controls and busy are decoded from the next state so they are
  // registered yet line up with the state they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt_reset  <= 1'b1;
      r_cnt_enable <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_cnt_reset  <= (w_next_state == S_IDLE) || (w_next_state == S_CLEAR);
      r_cnt_enable <= (w_next_state == S_RUN);
      r_busy       <= (w_next_state != S_IDLE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wd <= '0;
    end else if (r_state == S_CLEAR) begin
      r_wd <= '0;
    end else if (r_state == S_RUN) begin
      r_wd <= r_wd + WDW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_challenge <= '0;
      r_response  <= '0;
      r_lat_a     <= '0;
      r_lat_b     <= '0;
      r_valid     <= 1'b0;
      r_tie       <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_challenge <= '0;
        r_response  <= '0;
        r_valid     <= 1'b0;
        r_tie       <= 1'b0;
        r_error     <= 1'b0;
      end
      if (w_latch) begin
        r_lat_a <= bus.count_a;
        r_lat_b <= bus.count_b;
      end
      if (w_compare) begin
        r_response[r_challenge] <= (r_lat_a > r_lat_b);
        if (r_lat_a == r_lat_b) r_tie <= 1'b1;
        if (!w_last) r_challenge <= r_challenge + CHW'(1);
      end
      if (w_set_valid) r_valid <= 1'b1;
      if (w_set_error) begin
        r_error <= 1'b1;
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.cnt_reset  = r_cnt_reset;
  assign bus.cnt_enable = r_cnt_enable;
  assign bus.challenge  = r_challenge;
  assign bus.response   = r_response;
  assign bus.valid      = r_valid;
  assign bus.busy       = r_busy;
  assign bus.tie        = r_tie;
  assign bus.error      = r_error;
endmodule

// File: doc/puf_response_builder.md
# puf_response_builder

Sequencer and comparator directly downstream of the two post-mux counters in the parallel RO-PUF.
- Steps a challenge index through N_BITS ring-oscillator pair selections.
- For each index, clears and runs both counters and waits for both `finished` flags.
- Compares the two counts and packs one response bit per challenge into an N_BITS response word.
- Presents the word with a valid flag to the readout logic.

## Interface
- `N_BITS`, 8, response width; number of challenges per run (≥2)
- `CW`, 8, count width of each post-mux counter
- `TIMEOUT`, 4096, max cycles in RUN before abort (≥1)

- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle request to generate a response; ignored while `busy`
- `count_a`  in  CW  result of counter A (mux A output path)
- `fin_a`  in  1  counter A finished
- `count_b`  in  CW  result of counter B
- `fin_b`  in  1  counter B finished
- `cnt_reset`  out  1  active-high reset to both post-mux counters
- `cnt_enable`  out  1  enable to both post-mux counters
- `challenge`  out  $clog2(N_BITS)  current challenge index; drives the RO mux selects
- `response`  out  N_BITS  assembled response; bit i = result of challenge i
- `valid`  out  1  response complete; held until next accepted `start` or error
- `busy`  out  1  high in every state except IDLE
- `tie`  out  1  sticky; set if any challenge in the current run had `count_a == count_b`
- `error`  out  1  sticky; set on timeout; cleared by next accepted `start`

## Operation
- States: IDLE, CLEAR, RUN, COMPARE, DONE.
- IDLE:
  - Drives `cnt_reset`=1 and `cnt_enable`=0.
  - `start`=1 moves to CLEAR and loads `challenge`=0, `response`=0.
  - The same transition clears `valid`, `tie` and `error`.
- CLEAR:
  - Drives `cnt_reset`=1 and `cnt_enable`=0 for exactly one cycle.
  - Clears the watchdog, then moves to RUN.
- RUN:
  - Drives `cnt_reset`=0 and `cnt_enable`=1; the watchdog increments every cycle.
  - `fin_a && fin_b` moves to COMPARE and latches `count_a` and `count_b` that same cycle.
  - When the watchdog reaches TIMEOUT-1 without both flags, moves to IDLE with `error`=1 and `valid`=0.
  - One flag high alone keeps waiting; the counters hold their own result.
- COMPARE:
  - Drives `cnt_enable`=0 and `cnt_reset`=0.
  - Writes `response[challenge]` = (latched_a > latched_b), an unsigned compare. Equal counts write 0 and set `tie`.
  - If `challenge` == N_BITS-1, moves to DONE. Otherwise increments `challenge` and moves to CLEAR.
- DONE: sets `valid`=1 and moves to IDLE next cycle. `response`, `valid`, `tie` and `challenge` hold in IDLE.
- `start` outside IDLE is ignored entirely, with no queuing.
- `challenge` never wraps within a run. It resets to 0 only on an accepted `start` or on `reset`.

## Timing
- All outputs are registered.
- Reset values:
  - `cnt_reset`=1, `cnt_enable`=0
  - `challenge`=0, `response`=0
  - `valid`=0, `busy`=0, `tie`=0, `error`=0
  - state=IDLE
- `start` sampled at cycle t gives `busy`=1 and `cnt_reset`=1 at t+1, then `cnt_enable`=1 at t+2.
- Per challenge: 1 CLEAR cycle, then R RUN cycles (R ≥ 1, counted up to and including the cycle both flags are high), then 1 COMPARE cycle.
- `challenge` changes on the cycle after COMPARE and is stable for all of CLEAR and RUN. The mux has a full CLEAR cycle to settle before counting.
- `valid` rises 1 cycle after the last COMPARE. Total latency from `start` = N_BITS·(2+R) + 2 cycles.
- Timeout: `error` and `busy`=0 appear TIMEOUT cycles after RUN entry. `cnt_reset`=1 from that same cycle.
- `reset` asserted mid-run immediately forces all reset values. The counters are held in reset via `cnt_reset`=1. A partial response is discarded.

## Test plan
- Reset:
  - Stimulus: `reset`=0 for 3 cycles, then release with no `start`.
  - Required: all outputs at reset values, `cnt_reset`=1, state stays IDLE for 20 cycles.
- Full run, A always faster:
  - Stimulus: `count_a`=200, `count_b`=150, both fins high 10 cycles after enable, N_BITS=8.
  - Required: `response`=8'hFF, `valid`=1, `tie`=0.
  - Required: `challenge` steps 0..7; `cnt_reset` pulses 1 cycle before every RUN.
- Mixed pattern:
  - Stimulus: A>B on even challenges, A<B on odd.
  - Required: `response`=8'h55, latency = 8·(2+10)+2 = 98 cycles from `start` to `valid`.
- Tie and max values:
  - Stimulus: challenge 3 has A=B=255; challenge 4 has A=255, B=0; all others A<B.
  - Required: `response`=8'h10, `tie`=1.
- Timeout:
  - Stimulus: TIMEOUT=16, `fin_b` held 0.
  - Required: `error`=1, `busy`=0, `valid`=0 exactly 16 cycles after entering RUN.
  - Required: the next `start` clears `error` and a good run completes.
- Ignored start and mid-run reset:
  - Stimulus: pulse `start` during RUN of challenge 2.
  - Required: no effect.
  - Stimulus: then assert `reset` during challenge 5.
  - Required: immediate return to reset values; a following `start` completes a correct response.
